// File: rtl/i2c_txn_sequencer.sv
// Runs complete I2C transactions through the i2c_controller register port, streaming bytes via valid/ready FIFOs.
// Optional feature macro: I2C_SEQ_TIMEOUT_EN enables the status-poll timeout abort (err = 2'b10).
module i2c_txn_sequencer #(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic        CLK,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [6:0]  cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  rd_data,
    output logic        done,
    output logic [1:0]  err,
    output logic        chip_sel,
    output logic        chip_en,
    output logic        chip_write,
    output logic [7:0]  chip_addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CFG_CNT = 4'd1,
        ST_CFG_SLV = 4'd2,
        ST_START   = 4'd3,
        ST_POLL    = 4'd4,
        ST_EVAL    = 4'd5,
        ST_XFER    = 4'd6,
        ST_FLUSH   = 4'd7,
        ST_STOP    = 4'd8,
        ST_FINISH  = 4'd9
    } state_t;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_COUNT  = 8'h04;
    localparam logic [7:0] REG_SLAVE  = 8'h08;
    localparam logic [7:0] REG_STATUS = 8'h0C;
    localparam logic [7:0] REG_DIN    = 8'h10;
    localparam logic [7:0] REG_DOUT   = 8'h14;
    localparam logic [7:0] MAX_LEN_C  = 8'(MAX_LEN);

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_NACK = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;
    localparam logic [1:0] ERR_LEN  = 2'b11;

    state_t      state_r, state_s;
    logic        rw_r, rw_s;
    logic [6:0]  addr_r, addr_s;
    logic [7:0]  remaining_r, remaining_s;
    logic [4:1]  status_r, status_s;
    logic [1:0]  err_r, err_s;
    logic        rd_valid_r, rd_valid_s;
    logic [7:0]  rd_data_r, rd_data_s;
    logic        cmd_ready_r, cmd_ready_s;
    logic        wr_ready_r, wr_ready_s;
    logic        done_r, done_s;
    logic        sel_r, sel_s;
    logic        write_r, write_s;
    logic [7:0]  caddr_r, caddr_s;
    logic [7:0]  wdata_r, wdata_s;
    logic        rdata_unused_s;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_r, tmo_s;
`endif

    // The register port only carries byte-wide data; the upper read bits are ignored.
    assign rdata_unused_s = ^rdata[31:8];

    // Next-state and datapath update logic
    always_comb begin
        state_s     = state_r;
        rw_s        = rw_r;
        addr_s      = addr_r;
        remaining_s = remaining_r;
        status_s    = status_r;
        err_s       = err_r;
        rd_data_s   = rd_data_r;
`ifdef I2C_SEQ_TIMEOUT_EN
        tmo_s       = tmo_r;
`endif
        if (rd_valid_r && rd_ready) begin
            rd_valid_s = 1'b0;
        end else begin
            rd_valid_s = rd_valid_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if ((cmd_len == 8'd0) || (cmd_len > MAX_LEN_C)) begin
                        err_s   = ERR_LEN;
                        state_s = ST_FINISH;
                    end else begin
                        rw_s        = cmd_rw;
                        addr_s      = cmd_addr;
                        remaining_s = cmd_len;
                        err_s       = ERR_OK;
`ifdef I2C_SEQ_TIMEOUT_EN
                        tmo_s       = {TMO_W{1'b0}};
`endif
                        state_s     = ST_CFG_CNT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CFG_CNT: state_s = ST_CFG_SLV;
            ST_CFG_SLV: state_s = ST_START;
            ST_START:   state_s = ST_POLL;
            ST_POLL: begin
                status_s = rdata[4:1];
                state_s  = ST_EVAL;
            end
            ST_EVAL: begin
                // Rule order matters: nack wins over any pending data movement.
                if (status_r[3]) begin
                    err_s   = ERR_NACK;
                    state_s = ST_STOP;
                end else if (!rw_r && status_r[1] && (remaining_r != 8'd0) && wr_valid) begin
                    state_s = ST_XFER;
                end else if (rw_r && status_r[2] && (remaining_r != 8'd0) && !rd_valid_r) begin
                    state_s = ST_XFER;
                end else if ((remaining_r == 8'd0) && status_r[4]) begin
                    err_s   = ERR_OK;
                    state_s = ST_STOP;
                end else begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    if (tmo_r == TMO_LAST) begin
                        err_s   = ERR_TMO;
                        state_s = ST_STOP;
                    end else begin
                        tmo_s   = tmo_r + TMO_W'(1);
                        state_s = ST_POLL;
                    end
`else
                    state_s = ST_POLL;
`endif
                end
            end
            ST_XFER: begin
                remaining_s = remaining_r - 8'd1;
`ifdef I2C_SEQ_TIMEOUT_EN
                tmo_s       = {TMO_W{1'b0}};
`endif
                if (rw_r) begin
                    rd_data_s  = rdata[7:0];
                    rd_valid_s = 1'b1;
                    state_s    = ST_FLUSH;
                end else begin
                    state_s = ST_POLL;
                end
            end
            ST_FLUSH:  state_s = ST_POLL;
            ST_STOP:   state_s = ST_FINISH;
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Register-port strobes and handshake pulses for the state being entered
    always_comb begin
        sel_s      = 1'b0;
        write_s    = 1'b0;
        caddr_s    = 8'h00;
        wdata_s    = 8'h00;
        wr_ready_s = 1'b0;
        done_s     = 1'b0;
        case (state_s)
            ST_CFG_CNT: begin
                sel_s   = 1'b1;
                write_s = 1'b1;
                caddr_s = REG_COUNT;
                wdata_s = remaining_s;
            end
            ST_CFG_SLV: begin
                sel_s   = 1'b1;
                write_s = 1'b1;
                caddr_s = REG_SLAVE;
                wdata_s = {addr_s, rw_s};
            end
            ST_START: begin
                sel_s   = 1'b1;
                write_s = 1'b1;
                caddr_s = REG_CTRL;
                wdata_s = {6'b000000, rw_s, 1'b1};
            end
            ST_POLL: begin
                sel_s   = 1'b1;
                caddr_s = REG_STATUS;
            end
            ST_XFER: begin
                sel_s = 1'b1;
                if (rw_s) begin
                    caddr_s = REG_DOUT;
                end else begin
                    write_s    = 1'b1;
                    caddr_s    = REG_DIN;
                    wdata_s    = wr_data;
                    wr_ready_s = 1'b1;
                end
            end
            ST_STOP: begin
                sel_s   = 1'b1;
                write_s = 1'b1;
                caddr_s = REG_CTRL;
                wdata_s = 8'h00;
            end
            ST_FINISH: done_s = 1'b1;
            default:   done_s = 1'b0;
        endcase
        cmd_ready_s = (state_s == ST_IDLE);
    end

    // State register and registered outputs
    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            rw_r        <= 1'b0;
            addr_r      <= 7'd0;
            remaining_r <= 8'd0;
            status_r    <= 4'd0;
            err_r       <= 2'b00;
            rd_valid_r  <= 1'b0;
            rd_data_r   <= 8'd0;
            cmd_ready_r <= 1'b1;
            wr_ready_r  <= 1'b0;
            done_r      <= 1'b0;
            sel_r       <= 1'b0;
            write_r     <= 1'b0;
            caddr_r     <= 8'h00;
            wdata_r     <= 8'h00;
`ifdef I2C_SEQ_TIMEOUT_EN
            tmo_r       <= {TMO_W{1'b0}};
`endif
        end else begin
            state_r     <= state_s;
            rw_r        <= rw_s;
            addr_r      <= addr_s;
            remaining_r <= remaining_s;
            status_r    <= status_s;
            err_r       <= err_s;
            rd_valid_r  <= rd_valid_s;
            rd_data_r   <= rd_data_s;
            cmd_ready_r <= cmd_ready_s;
            wr_ready_r  <= wr_ready_s;
            done_r      <= done_s;
            sel_r       <= sel_s;
            write_r     <= write_s;
            caddr_r     <= caddr_s;
            wdata_r     <= wdata_s;
`ifdef I2C_SEQ_TIMEOUT_EN
            tmo_r       <= tmo_s;
`endif
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign wr_ready   = wr_ready_r;
    assign rd_valid   = rd_valid_r;
    assign rd_data    = rd_data_r;
    assign done       = done_r;
    assign err        = err_r;
    assign chip_sel   = sel_r;
    assign chip_en    = sel_r;
    assign chip_write = write_r;
    assign chip_addr  = caddr_r;
    assign wdata      = {24'h000000, wdata_r};

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Self-checking bench for i2c_txn_sequencer: a behavioural register-port model plus a table of whole transactions.
module tb_i2c_txn_sequencer;

    localparam int TMO = 8;

    logic        CLK = 1'b0;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_data;
    logic        rd_valid, rd_ready;
    logic [7:0]  rd_data;
    logic        done;
    logic [1:0]  err;
    logic        chip_sel, chip_en, chip_write;
    logic [7:0]  chip_addr;
    logic [31:0] wdata, rdata;

    always #5 CLK = ~CLK;

    i2c_txn_sequencer #(.MAX_LEN(16), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .err(err),
        .chip_sel(chip_sel), .chip_en(chip_en), .chip_write(chip_write),
        .chip_addr(chip_addr), .wdata(wdata), .rdata(rdata)
    );

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] len;
        int         mode;      // 0 normal, 1 nack, 2 stuck busy
        logic [1:0] exp_err;
        int         exp_acc;   // expected 0x10 writes or 0x14 reads
        logic       exp_bus;   // any register access expected
        logic [7:0] exp_slv;
    } vec_t;

    vec_t vecs[7];

    int n_checks = 0;
    int n_fail   = 0;
    int mode, cnt_prog, data_acc, dout_idx, poll_cnt, done_cnt, acc_cyc, first_poll, wi, n_wr;
    logic take_wr;
    logic [7:0] log_addr[$];
    logic       log_wr[$];
    logic [7:0] log_data[$];
    logic [7:0] rx_q[$];

    function automatic logic [7:0] wr_of(input int i);
        case (i)
            0:       return 8'hA5;
            1:       return 8'h5A;
            2:       return 8'hFF;
            default: return 8'(i * 19);
        endcase
    endfunction

    function automatic logic [7:0] dout_of(input int i);
        case (i)
            0:       return 8'h12;
            1:       return 8'h34;
            default: return 8'(i * 37 + 1);
        endcase
    endfunction

    function automatic logic [7:0] status_now();
        if (mode == 1)      return 8'h09;
        else if (mode == 2) return 8'h01;
        else if (data_acc == cnt_prog) return 8'h10;
        else return 8'h07;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Register-port model, write-byte source and read-byte sink, all acting on the falling edge
    initial begin
        rdata = 32'h0; wr_valid = 1'b0; wr_data = 8'h00; take_wr = 1'b0;
        done_cnt = 0; acc_cyc = 0; wi = 0; n_wr = 0; mode = 0;
        cnt_prog = 0; data_acc = 0; dout_idx = 0; poll_cnt = 0; first_poll = -1;
        forever begin
            @(negedge CLK);
            if (take_wr) wi++;
            wr_valid = (wi < n_wr);
            wr_data  = wr_of(wi);
            take_wr  = wr_valid && wr_ready;
            if (rd_valid && rd_ready) rx_q.push_back(rd_data);
            if (done) done_cnt++;
            if (cmd_valid && cmd_ready) acc_cyc = 0;
            else acc_cyc++;
            if (chip_sel) begin
                check("chip_en_on_access", chip_en, 1'b1);
                check("wdata_upper_zero", wdata[31:8], 24'h0);
                if (chip_addr == 8'h0C && first_poll < 0) first_poll = acc_cyc;
                log_addr.push_back(chip_addr);
                log_wr.push_back(chip_write);
                log_data.push_back(wdata[7:0]);
                if (chip_write) begin
                    if (chip_addr == 8'h04) cnt_prog = int'(wdata[7:0]);
                    if (chip_addr == 8'h10) data_acc++;
                end else if (chip_addr == 8'h0C) begin
                    poll_cnt++;
                    rdata = {24'hC3A55A, status_now()};
                end else if (chip_addr == 8'h14) begin
                    rdata = {24'h5AA5C3, dout_of(dout_idx)};
                    dout_idx++;
                    data_acc++;
                end
            end
        end
    end

    task automatic prep(input int m, input int nw);
        @(posedge CLK); #1;
        mode = m; cnt_prog = 0; data_acc = 0; dout_idx = 0; poll_cnt = 0;
        wi = 0; n_wr = nw; take_wr = 1'b0; first_poll = -1;
        log_addr.delete(); log_wr.delete(); log_data.delete(); rx_q.delete();
    endtask

    task automatic issue_cmd(input logic rw, input logic [6:0] a, input logic [7:0] l);
        @(posedge CLK); #1;
        cmd_rw = rw; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!done && cyc < budget);
        check("done_within_budget", done, 1'b1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        int k;
        int last;
        prep(v.mode, v.rw ? 0 : int'(v.len));
        check($sformatf("v%0d_cmd_ready", idx), cmd_ready, 1'b1);
        issue_cmd(v.rw, v.addr, v.len);
        wait_done(400, cyc);
        check($sformatf("v%0d_err", idx), err, v.exp_err);
        check($sformatf("v%0d_data_acc", idx), data_acc, v.exp_acc);
        if (v.exp_bus) begin
            check($sformatf("v%0d_log_size", idx), log_addr.size() >= 5, 1'b1);
            if (log_addr.size() >= 5) begin
                last = log_addr.size() - 1;
                check($sformatf("v%0d_cnt_wr", idx), {log_addr[0], 7'd0, log_wr[0], log_data[0]}, {8'h04, 8'h01, v.len});
                check($sformatf("v%0d_slv_wr", idx), {log_addr[1], 7'd0, log_wr[1], log_data[1]}, {8'h08, 8'h01, v.exp_slv});
                check($sformatf("v%0d_start_wr", idx), {log_addr[2], 7'd0, log_wr[2], log_data[2]}, {8'h00, 8'h01, 6'd0, v.rw, 1'b1});
                check($sformatf("v%0d_stop_wr", idx), {log_addr[last], 7'd0, log_wr[last], log_data[last]}, {8'h00, 8'h01, 8'h00});
            end
            check($sformatf("v%0d_first_poll", idx), first_poll, 4);
        end else begin
            check($sformatf("v%0d_no_bus", idx), log_addr.size(), 0);
            check($sformatf("v%0d_done_latency", idx), cyc, 1);
        end
        if (!v.rw) begin
            k = 0;
            for (int j = 0; j < log_addr.size(); j++) begin
                if (log_wr[j] && log_addr[j] == 8'h10) begin
                    check($sformatf("v%0d_wbyte%0d", idx, k), log_data[j], wr_of(k));
                    k++;
                end
            end
        end else begin
            check($sformatf("v%0d_rx_count", idx), rx_q.size(), v.exp_acc);
            for (int j = 0; j < rx_q.size(); j++)
                check($sformatf("v%0d_rbyte%0d", idx, j), rx_q[j], dout_of(j));
        end
        @(negedge CLK);
        check($sformatf("v%0d_done_one_cycle", idx), done, 1'b0);
    endtask

    initial begin
        int cyc;
        int k;
        int d0;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 7'd0; cmd_len = 8'd0; rd_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1 rstn = 1'b1;
        @(negedge CLK);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 2'b00);
        check("rst_chip_sel", chip_sel, 1'b0);
        check("rst_chip_en", chip_en, 1'b0);
        check("rst_chip_write", chip_write, 1'b0);
        check("rst_chip_addr", chip_addr, 8'h00);
        check("rst_wdata", wdata, 32'h0);
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);

        vecs[0] = '{rw:1'b0, addr:7'h50, len:8'd3,  mode:0, exp_err:2'b00, exp_acc:3,  exp_bus:1'b1, exp_slv:8'hA0};
        vecs[1] = '{rw:1'b1, addr:7'h68, len:8'd2,  mode:0, exp_err:2'b00, exp_acc:2,  exp_bus:1'b1, exp_slv:8'hD1};
        vecs[2] = '{rw:1'b0, addr:7'h2A, len:8'd1,  mode:1, exp_err:2'b01, exp_acc:0,  exp_bus:1'b1, exp_slv:8'h54};
        vecs[3] = '{rw:1'b1, addr:7'h11, len:8'd16, mode:0, exp_err:2'b00, exp_acc:16, exp_bus:1'b1, exp_slv:8'h23};
        vecs[4] = '{rw:1'b0, addr:7'h33, len:8'd0,  mode:0, exp_err:2'b11, exp_acc:0,  exp_bus:1'b0, exp_slv:8'h00};
        vecs[5] = '{rw:1'b1, addr:7'h33, len:8'd17, mode:0, exp_err:2'b11, exp_acc:0,  exp_bus:1'b0, exp_slv:8'h00};
        vecs[6] = '{rw:1'b0, addr:7'h7F, len:8'd16, mode:0, exp_err:2'b00, exp_acc:16, exp_bus:1'b1, exp_slv:8'hFE};

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Read with rd_ready held low; a command offered meanwhile must be ignored
        prep(0, 0);
        rd_ready = 1'b0;
        issue_cmd(1'b1, 7'h68, 8'd2);
        k = 0;
        while (!rd_valid && k < 100) begin
            @(negedge CLK);
            k++;
        end
        check("hold_rd_valid_seen", rd_valid, 1'b1);
        d0 = done_cnt;
        @(posedge CLK); #1;
        cmd_len = 8'd0; cmd_valid = 1'b1;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        repeat (20) @(posedge CLK);
        @(negedge CLK);
        check("hold_dout_reads", dout_idx, 1);
        check("hold_rd_valid_kept", rd_valid, 1'b1);
        check("hold_rd_data", rd_data, 8'h12);
        @(posedge CLK); #1;
        rd_ready = 1'b1;
        wait_done(200, cyc);
        check("hold_err", err, 2'b00);
        check("hold_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("hold_rx0", rx_q[0], 8'h12);
            check("hold_rx1", rx_q[1], 8'h34);
        end
        repeat (5) @(negedge CLK);
        check("ignored_cmd_single_done", done_cnt - d0, 1);
        check("ignored_cmd_idle", cmd_ready, 1'b1);

`ifdef I2C_SEQ_TIMEOUT_EN
        prep(2, 1);
        issue_cmd(1'b0, 7'h10, 8'd1);
        wait_done(300, cyc);
        check("tmo_err", err, 2'b10);
        check("tmo_polls", poll_cnt, TMO);
        check("tmo_no_data", data_acc, 0);
        prep(2, 1);
        issue_cmd(1'b0, 7'h10, 8'd1);
`else
        prep(2, 1);
        issue_cmd(1'b0, 7'h10, 8'd1);
        d0 = done_cnt;
        repeat (60) @(negedge CLK);
        check("stuck_no_done", done_cnt - d0, 0);
        check("stuck_keeps_polling", poll_cnt > 20, 1'b1);
`endif
        // Reset asserted while a status poll is on the bus
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!(chip_sel && chip_addr == 8'h0C) && k < 50);
        check("rst_mid_poll_seen", chip_sel && chip_addr == 8'h0C, 1'b1);
        rstn = 1'b0;
        #1;
        check("midrst_chip_sel", chip_sel, 1'b0);
        check("midrst_chip_en", chip_en, 1'b0);
        check("midrst_chip_write", chip_write, 1'b0);
        check("midrst_cmd_ready", cmd_ready, 1'b1);
        check("midrst_done", done, 1'b0);
        @(posedge CLK); #1;
        rstn = 1'b1;
        @(negedge CLK);
        check("postrst_idle", cmd_ready, 1'b1);
        check("postrst_err", err, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
